// File: rtl/keyboard_serializer_if.sv
// Host bus and key-op handshake bundle for keyboard_serializer.
// The master side is the host/receiver environment; the slave side is the serializer.
interface keyboard_serializer_if;
    logic        HOST_WR;
    logic [3:0]  HOST_A;
    logic [7:0]  HOST_DI;
    logic [7:0]  HOST_DO;
    logic        FLUSH;
    logic        PENDING;
    logic        KEY_STB;
    logic [11:0] KEY_OP;
    logic        KEY_BUSY;

    modport master (
        output HOST_WR, HOST_A, HOST_DI, FLUSH, KEY_BUSY,
        input  HOST_DO, PENDING, KEY_STB, KEY_OP
    );

    modport slave (
        input  HOST_WR, HOST_A, HOST_DI, FLUSH, KEY_BUSY,
        output HOST_DO, PENDING, KEY_STB, KEY_OP
    );
endinterface

// File: rtl/keyboard_serializer.sv
// Keyboard matrix shadow (8 rows + modifier) with dirty tracking, serialised to a
// key-op receiver over a four-phase strobe/busy handshake.
module keyboard_serializer (
    input  logic                  CLK,
    input  logic                  RESET,
    keyboard_serializer_if.slave  kbd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            key_stb_q, key_stb_d;
    logic [11:0]     key_op_q, key_op_d;
    logic [8:0][7:0] shadow_q, shadow_d;
    logic [8:0]      dirty_q, dirty_d;
    logic [8:0]      set_s;
    logic [8:0]      clr_s;
    logic [3:0]      sel_s;

    // Modifier (index 8) always wins; otherwise the lowest dirty row is chosen.
    function automatic logic [3:0] pick_entry(input logic [8:0] dirty);
        logic [3:0] idx;
        idx = 4'd8;
        if (!dirty[8]) begin
            for (int i = 7; i >= 0; i--) begin
                idx = dirty[i] ? 4'(i) : idx;
            end
        end else begin
            idx = 4'd8;
        end
        return idx;
    endfunction

    // Host writes and flush: shadow update plus dirty-set mask.
    always_comb begin
        shadow_d = shadow_q;
        set_s    = 9'h000;
        if (kbd.HOST_WR && (kbd.HOST_A <= 4'd8)) begin
            shadow_d[kbd.HOST_A] = kbd.HOST_DI;
            set_s[kbd.HOST_A]    = 1'b1;
        end else begin
            set_s = 9'h000;
        end
        if (kbd.FLUSH) begin
            set_s = 9'h1FF;
        end else begin
            set_s = set_s;
        end
    end

    // Handshake sequencing; op data is latched once in IDLE and never touched in flight.
    always_comb begin
        sel_s     = pick_entry(dirty_q);
        clr_s     = 9'h000;
        state_d   = state_q;
        key_stb_d = key_stb_q;
        key_op_d  = key_op_q;
        case (state_q)
            ST_IDLE: begin
                if (|dirty_q) begin
                    clr_s[sel_s] = 1'b1;
                    key_stb_d    = 1'b1;
                    state_d      = ST_REQ;
                    if (sel_s == 4'd8) begin
                        key_op_d = {1'b1, 3'b000, shadow_q[8]};
                    end else begin
                        key_op_d = {1'b0, sel_s[2:0], shadow_q[sel_s]};
                    end
                end else begin
                    key_stb_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (kbd.KEY_BUSY) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_ACK: begin
                if (!kbd.KEY_BUSY) begin
                    key_stb_d = 1'b0;
                    state_d   = ST_GAP;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                key_stb_d = 1'b0;
            end
        endcase
        // A set in the same cycle as the clear keeps the entry dirty.
        dirty_d = (dirty_q & ~clr_s) | set_s;
    end

    // State, op register, shadow and dirty flops; reset forces a full resync.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            key_stb_q <= 1'b0;
            key_op_q  <= 12'h000;
            shadow_q  <= {9{8'hFF}};
            dirty_q   <= 9'h1FF;
        end else begin
            state_q   <= state_d;
            key_stb_q <= key_stb_d;
            key_op_q  <= key_op_d;
            shadow_q  <= shadow_d;
            dirty_q   <= dirty_d;
        end
    end

    // Combinational shadow readback; unmapped addresses read all-released.
    always_comb begin
        if (kbd.HOST_A <= 4'd8) begin
            kbd.HOST_DO = shadow_q[kbd.HOST_A];
        end else begin
            kbd.HOST_DO = 8'hFF;
        end
    end

    assign kbd.KEY_STB = key_stb_q;
    assign kbd.KEY_OP  = key_op_q;
    assign kbd.PENDING = (|dirty_q) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_keyboard_serializer.sv
// Self-checking bench for keyboard_serializer: model receiver, op monitor and a
// behavioural shadow model that predicts the op stream from the priority rules.
module tb_keyboard_serializer;

    logic CLK = 1'b0;
    logic RESET;
    keyboard_serializer_if bus ();

    keyboard_serializer dut (.CLK(CLK), .RESET(RESET), .kbd(bus.slave));

    always #5 CLK = ~CLK;

    int          n_cmp;
    int          n_err;
    logic [7:0]  mdl[9];
    logic [11:0] ops[$];
    logic [11:0] exp_q[$];
    int          min_gap;
    int          stable_viol;

    // Receiver: BUSY rises 1 cycle after it sees STB, stays high 2 cycles.
    bit rx_en;
    int rx_cnt;
    bit rx_armed;
    always @(posedge CLK) begin
        if (RESET || !rx_en) begin
            bus.KEY_BUSY <= 1'b0;
            rx_cnt       <= 0;
            rx_armed     <= 1'b0;
        end else if (rx_cnt != 0) begin
            rx_cnt <= rx_cnt - 1;
            if (rx_cnt == 1) bus.KEY_BUSY <= 1'b0;
        end else if (bus.KEY_STB && !rx_armed) begin
            bus.KEY_BUSY <= 1'b1;
            rx_cnt       <= 2;
            rx_armed     <= 1'b1;
        end else if (!bus.KEY_STB) begin
            rx_armed <= 1'b0;
        end
    end

    // Monitor: log each op on STB rise, track rise-to-rise spacing and op stability.
    bit          mon_prev;
    bit          mon_have;
    int          mon_since;
    logic [11:0] mon_held;
    always @(negedge CLK) begin
        if (RESET) begin
            mon_prev  = 1'b0;
            mon_have  = 1'b0;
            mon_since = 0;
        end else begin
            mon_since++;
            if (bus.KEY_STB && !mon_prev) begin
                ops.push_back(bus.KEY_OP);
                if (mon_have && mon_since < min_gap) min_gap = mon_since;
                mon_since = 0;
                mon_have  = 1'b1;
                mon_held  = bus.KEY_OP;
            end else if (bus.KEY_STB && bus.KEY_OP !== mon_held) begin
                stable_viol++;
            end
            mon_prev = bus.KEY_STB;
        end
    end

    function automatic void add_full_sync();
        exp_q.push_back({1'b1, 3'b000, mdl[8]});
        for (int r = 0; r < 8; r++) exp_q.push_back({1'b0, 3'(r), mdl[r]});
    endfunction

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        bus.HOST_WR = 1'b1;
        bus.HOST_A  = a;
        bus.HOST_DI = d;
        @(negedge CLK);
        bus.HOST_WR = 1'b0;
        if (a <= 4'd8) mdl[a] = d;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (bus.PENDING !== 1'b0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        n_cmp++;
        if (bus.PENDING !== 1'b0) begin
            n_err++;
            $display("FAIL drain_timeout: PENDING=%b after %0d cycles, expected 0", bus.PENDING, k);
        end
    endtask

    task automatic wait_level(input bit want_busy, input int budget);
        int k = 0;
        while ((want_busy ? bus.KEY_BUSY : bus.KEY_STB) !== 1'b1 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        n_cmp++;
        if ((want_busy ? bus.KEY_BUSY : bus.KEY_STB) !== 1'b1) begin
            n_err++;
            $display("FAIL wait_%s: still low after %0d cycles, expected high", want_busy ? "busy" : "stb", k);
        end
    endtask

    task automatic test_reset();
        RESET       = 1'b1;
        bus.HOST_WR = 1'b1;
        bus.HOST_A  = 4'd3;
        bus.HOST_DI = 8'h00;
        bus.FLUSH   = 1'b1;
        repeat (3) @(negedge CLK);
        bus.HOST_WR = 1'b0;
        bus.FLUSH   = 1'b0;
        n_cmp++;
        if (bus.KEY_STB !== 1'b0 || bus.KEY_OP !== 12'h000 || bus.PENDING !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: stb=%b op=%h pend=%b, expected 0 000 1", bus.KEY_STB, bus.KEY_OP, bus.PENDING);
        end
        for (int a = 0; a < 16; a++) begin
            bus.HOST_A = 4'(a);
            #1;
            n_cmp++;
            if (bus.HOST_DO !== 8'hFF) begin
                n_err++;
                $display("FAIL reset_readback a=%0d: got %h expected ff", a, bus.HOST_DO);
            end
        end
        @(negedge CLK);
        exp_q.delete();
        add_full_sync();
        begin
            int start = ops.size();
            min_gap = 1000;
            RESET = 1'b0;
            wait_idle(200);
            n_cmp++;
            if (ops.size() - start != exp_q.size()) begin
                n_err++;
                $display("FAIL reset_seq_len: got %0d ops expected %0d", ops.size() - start, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (start + i >= ops.size() || ops[start + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL reset_seq[%0d]: got %h expected %h", i,
                             (start + i < ops.size()) ? ops[start + i] : 12'h000, exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (min_gap !== 6 || stable_viol !== 0) begin
            n_err++;
            $display("FAIL reset_spacing: min_gap=%0d viol=%0d expected 6 and 0", min_gap, stable_viol);
        end
    endtask

    task automatic test_single();
        int start = ops.size();
        do_write(4'd5, 8'hFE);
        @(negedge CLK);
        bus.HOST_A = 4'd5;
        #1;
        n_cmp++;
        if (bus.KEY_STB !== 1'b1 || bus.KEY_OP !== 12'h5FE || bus.HOST_DO !== 8'hFE) begin
            n_err++;
            $display("FAIL single_op: stb=%b op=%h do=%h expected 1 5fe fe", bus.KEY_STB, bus.KEY_OP, bus.HOST_DO);
        end
        wait_idle(50);
        n_cmp++;
        if (ops.size() - start != 1 || ops[ops.size() - 1] !== 12'h5FE || stable_viol !== 0) begin
            n_err++;
            $display("FAIL single_seq: count=%0d last=%h viol=%0d expected 1 5fe 0",
                     ops.size() - start, ops[ops.size() - 1], stable_viol);
        end
    endtask

    task automatic check_seq(input string name, input int start);
        n_cmp++;
        if (ops.size() - start != exp_q.size()) begin
            n_err++;
            $display("FAIL %s_len: got %0d ops expected %0d", name, ops.size() - start, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (start + i >= ops.size() || ops[start + i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h expected %h", name, i,
                         (start + i < ops.size()) ? ops[start + i] : 12'h000, exp_q[i]);
            end
        end
    endtask

    task automatic test_priority();
        int start = ops.size();
        rx_en = 1'b0;
        do_write(4'd0, 8'hA5);
        wait_level(1'b0, 10);
        do_write(4'd2, 8'h7F);
        do_write(4'd8, 8'hFD);
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (bus.KEY_STB !== 1'b1 || bus.KEY_OP !== 12'h0A5) begin
            n_err++;
            $display("FAIL priority_hold: stb=%b op=%h expected 1 0a5", bus.KEY_STB, bus.KEY_OP);
        end
        rx_en = 1'b1;
        wait_idle(100);
        exp_q = '{12'h0A5, 12'h8FD, 12'h27F};
        check_seq("priority", start);
    endtask

    task automatic test_back_to_back();
        int start = ops.size();
        do_write(4'd3, 8'hEF);
        do_write(4'd3, 8'hDF);
        wait_idle(100);
        exp_q = '{12'h3EF, 12'h3DF};
        check_seq("b2b_same_entry", start);
    endtask

    task automatic test_ack_write();
        int start = ops.size();
        do_write(4'd3, 8'hEF);
        wait_level(1'b1, 10);
        @(negedge CLK);
        do_write(4'd3, 8'hDF);
        n_cmp++;
        if (bus.KEY_STB !== 1'b1 || bus.KEY_OP !== 12'h3EF) begin
            n_err++;
            $display("FAIL ack_write_hold: stb=%b op=%h expected 1 3ef", bus.KEY_STB, bus.KEY_OP);
        end
        wait_idle(100);
        exp_q = '{12'h3EF, 12'h3DF};
        check_seq("ack_write", start);
    endtask

    task automatic test_stall();
        int start = ops.size();
        rx_en = 1'b0;
        do_write(4'd1, 8'h3C);
        wait_level(1'b0, 10);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            n_cmp++;
            if (bus.KEY_STB !== 1'b1 || bus.KEY_OP !== 12'h13C || bus.PENDING !== 1'b1) begin
                n_err++;
                $display("FAIL stall_c%0d: stb=%b op=%h pend=%b expected 1 13c 1", c, bus.KEY_STB, bus.KEY_OP, bus.PENDING);
            end
        end
        rx_en = 1'b1;
        wait_idle(100);
        exp_q = '{12'h13C};
        check_seq("stall", start);
    endtask

    task automatic test_reset_mid();
        int start;
        do_write(4'd6, 8'h55);
        wait_level(1'b1, 10);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (bus.KEY_STB !== 1'b0 || bus.KEY_OP !== 12'h000) begin
            n_err++;
            $display("FAIL reset_mid_drop: stb=%b op=%h expected 0 000", bus.KEY_STB, bus.KEY_OP);
        end
        for (int e = 0; e < 9; e++) mdl[e] = 8'hFF;
        start = ops.size();
        RESET = 1'b0;
        wait_idle(200);
        exp_q.delete();
        add_full_sync();
        check_seq("reset_mid_resync", start);
    endtask

    task automatic test_flush_random();
        int          start = ops.size();
        logic [7:0]  d0;
        d0 = 8'($urandom);
        rx_en = 1'b0;
        do_write(4'd4, d0);
        wait_level(1'b0, 10);
        for (int e = 0; e < 9; e++) begin
            if ($urandom_range(0, 1) == 1) do_write(4'(e), 8'($urandom));
        end
        do_write(4'($urandom_range(9, 15)), 8'h00);
        bus.FLUSH = 1'b1;
        @(negedge CLK);
        bus.FLUSH = 1'b0;
        rx_en = 1'b1;
        wait_idle(300);
        exp_q.delete();
        exp_q.push_back({1'b0, 3'd4, d0});
        add_full_sync();
        check_seq("flush", start);
        // FLUSH landing on the same edge that IDLE clears row 7.
        start = ops.size();
        do_write(4'd7, 8'h12);
        bus.FLUSH = 1'b1;
        @(negedge CLK);
        bus.FLUSH = 1'b0;
        wait_idle(300);
        exp_q.delete();
        exp_q.push_back(12'h712);
        add_full_sync();
        check_seq("flush_collide", start);
    endtask

    task automatic test_random();
        min_gap = 1000;
        for (int c = 0; c < 120; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_write(4'($urandom_range(0, 15)), 8'($urandom));
            end else begin
                @(negedge CLK);
            end
        end
        wait_idle(600);
        for (int e = 0; e < 9; e++) begin
            logic [7:0] last;
            bit         found;
            found = 1'b0;
            last  = 8'h00;
            foreach (ops[i]) begin
                if ((ops[i][11] ? 8 : int'(ops[i][10:8])) == e) begin
                    last  = ops[i][7:0];
                    found = 1'b1;
                end
            end
            bus.HOST_A = 4'(e);
            #1;
            n_cmp++;
            if (!found || last !== mdl[e] || bus.HOST_DO !== mdl[e]) begin
                n_err++;
                $display("FAIL random_entry%0d: last_sent=%h readback=%h expected %h", e, last, bus.HOST_DO, mdl[e]);
            end
        end
        n_cmp++;
        if (min_gap < 6 || stable_viol !== 0) begin
            n_err++;
            $display("FAIL random_spacing: min_gap=%0d viol=%0d expected >=6 and 0", min_gap, stable_viol);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        min_gap     = 1000;
        stable_viol = 0;
        rx_en       = 1'b1;
        RESET       = 1'b1;
        bus.HOST_WR = 1'b0;
        bus.HOST_A  = 4'd0;
        bus.HOST_DI = 8'h00;
        bus.FLUSH   = 1'b0;
        for (int e = 0; e < 9; e++) mdl[e] = 8'hFF;
        @(negedge CLK);
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_ack_write();
        test_stall();
        test_reset_mid();
        test_flush_random();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keyboard_serializer.md
KEYBOARD_SERIALIZER -- requirements
Module: keyboard_serializer

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-003 SHALL have port HOST_WR, input, 1, host write strobe, one write per asserted cycle.
REQ-004 SHALL have port HOST_A, input, 4, host address: 0-7 selects a matrix row, 8 selects the modifier register, 9-15 are ignored.
REQ-005 SHALL have port HOST_DI, input, 8, host write data; bits are active-low (0 = key pressed).
REQ-006 SHALL have port HOST_DO, output, 8, combinational readback of the shadow entry at HOST_A; reads 8'hFF for addresses 9-15.
REQ-007 SHALL have port FLUSH, input, 1, marks all 9 entries dirty.
REQ-008 SHALL have port PENDING, output, 1, high while any dirty bit is set or a transfer is in progress.
REQ-009 SHALL have port KEY_STB, output, 1, registered request strobe to the key-op receiver.
REQ-010 SHALL have port KEY_OP, output, 12, registered op word, held stable while KEY_STB is high.
REQ-011 SHALL have port KEY_BUSY, input, 1, receiver acknowledge.

Function
REQ-012 SHALL hold 9 shadow registers of 8 bits (ROW0-ROW7, MOD) and 9 dirty bits.
REQ-013 On HOST_WR with HOST_A 0-8, SHALL write HOST_DI into the addressed shadow register and set its dirty bit, even if the data is unchanged.
REQ-014 Op encoding for a row: KEY_OP[11]=0, [10:8]=row index, [7:0]=shadow row data.
REQ-015 Op encoding for the modifier: KEY_OP[11]=1, [10:8]=3'b000, [7:0]=shadow MOD data.
REQ-016 SHALL implement the FSM IDLE -> REQ -> ACK -> GAP -> IDLE.
REQ-017 IDLE: if any dirty bit is set, SHALL select an entry with MOD highest priority, then the lowest row index.
REQ-018 IDLE: on that edge SHALL load KEY_OP from the selected entry's current shadow data, set KEY_STB=1, clear that dirty bit and go to REQ.
REQ-019 REQ: SHALL hold KEY_STB=1 and KEY_OP unchanged until KEY_BUSY=1 is sampled, then go to ACK; a KEY_BUSY=0 sampled in REQ SHALL NOT count as completion.
REQ-020 ACK: SHALL hold KEY_STB=1 until KEY_BUSY=0 is sampled; on that edge SHALL drive KEY_STB=0 and go to GAP.
REQ-021 GAP: SHALL keep KEY_STB=0 for exactly one cycle, then go to IDLE; this guarantees KEY_STB low for at least 1 cycle between ops.
REQ-022 Minimum time from KEY_STB rise to the next KEY_STB rise SHALL be 6 cycles against a receiver that raises BUSY 1 cycle after STB and drops it 2 cycles later.
REQ-023 If a host write and a dirty-clear target the same entry in the same cycle, set SHALL win: the entry stays dirty and the new data is sent by a later op; the op in flight keeps its latched data.
REQ-024 Host writes to other entries during REQ, ACK or GAP SHALL only set dirty bits and SHALL NOT disturb KEY_OP.
REQ-025 FLUSH SHALL set all 9 dirty bits; if FLUSH coincides with a dirty-clear, FLUSH wins.
REQ-026 PENDING SHALL be combinational: OR of the dirty bits, OR state != IDLE.
REQ-027 The block SHALL NOT time out; it waits indefinitely in REQ or ACK.

Reset
REQ-028 While RESET=1: state SHALL be IDLE, KEY_STB=0, KEY_OP=12'h000, all shadow registers 8'hFF, all 9 dirty bits set.
REQ-029 RESET SHALL take priority over HOST_WR and FLUSH in the same cycle.
REQ-030 RESET asserted mid-transfer SHALL drop KEY_STB on the next edge with no further handshake wait.
REQ-031 Consequence of REQ-028: after reset the block SHALL send MOD then ROW0..ROW7, each carrying 8'hFF, to initialise the receiver.

Verification
REQ-032 Reset release with a model receiver (BUSY 1 cycle after STB, high for 2 cycles) -> 9 ops in order 12'h8FF, 12'h0FF, 12'h1FF ... 12'h7FF, KEY_STB low >=1 cycle between ops, then PENDING=0.
REQ-033 Idle block; HOST_WR A=5 DI=8'hFE -> next edge KEY_STB=1, KEY_OP=12'h5FE; held until BUSY falls; HOST_DO at A=5 reads 8'hFE.
REQ-034 Write row 2 =8'h7F and MOD =8'hFD in the same idle window -> ops 12'h8FD then 12'h27F.
REQ-035 During ACK of row 3 (data 8'hEF), write row 3 =8'hDF -> in-flight KEY_OP stays 12'h3EF; a second op 12'h3DF follows.
REQ-036 Receiver holds BUSY=0 for 20 cycles after STB -> KEY_STB stays 1, KEY_OP stable, no completion.
REQ-037 Assert RESET while in ACK -> KEY_STB=0 next edge, then the full 9-op resync sequence follows release.
